sar_compare_search: RTL

//  Successive-approximation controller that drives the "a" side of an external

---
 rtl/sar_compare_search.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sar_compare_search.sv
// sar_compare_search
//   Successive-approximation controller for an external magnitude comparator.
//   It drives a trial value onto the comparator "a" input and reads back GT/LT.
//   The trial is binary-searched MSB first until it converges on the unknown
//   "b" operand. At the end it reports the converged value, an equality
//   confirmation and a sticky protocol-error flag.
//
//   Parameters
//     WIDTH      operand width, 1..16
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high reset
//     start      search request, sampled only while idle
//     gt_in      comparator GT (trial_out > b)
//     lt_in      comparator LT (trial_out < b)
//     trial_out  value presented to the comparator
//     busy       search in progress (TEST/CHECK)
//     done       one-cycle completion pulse
//     result     converged value, held until the next accepted start
//     found      final sample showed equality
//     err        gt_in and lt_in were both seen high during this search
//
//   Build option
//     SAR_EARLY_EXIT_EN  when defined, a legal equal sample during TEST ends
//                        the search immediately and CHECK is skipped.

module sar_compare_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic [WIDTH-1:0] trial_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    TEST,
    CHECK,
    DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [KW-1:0]   k;
  logic [WIDTH-1:0] cur_bit;
  logic [WIDTH-1:0] trial_next;
  logic            equal;
  logic            illegal;

  assign equal   = ~gt_in & ~lt_in;
  assign illegal = gt_in & lt_in;

  // Bit k is cleared on GT (an illegal GT+LT sample also clears it); the next
  // lower bit is then set as the following guess. At k==0 no lower bit exists.
  always_comb begin
    cur_bit    = WIDTH'(1) << k;
    trial_next = trial_out;
    if (gt_in) begin
      trial_next = trial_next & ~cur_bit;
    end
    trial_next = trial_next | (cur_bit >> 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = TEST;
      TEST: begin
`ifdef SAR_EARLY_EXIT_EN
        if (equal) begin
          next_state = DONE;
        end else if (k == '0) begin
          next_state = CHECK;
        end
`else
        if (k == '0) begin
          next_state = CHECK;
        end
`endif
      end
      CHECK: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      TEST, CHECK: busy = 1'b1;
      DONE:        done = 1'b1;
      default: ;
    endcase
  end

  // Search datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      trial_out <= '0;
      k         <= '0;
      result    <= '0;
      found     <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            trial_out <= TOP_BIT;
            k         <= KW'(WIDTH - 1);
            found     <= 1'b0;
            err       <= 1'b0;
          end
        end
        TEST: begin
`ifdef SAR_EARLY_EXIT_EN
          if (equal) begin
            result <= trial_out;
            found  <= 1'b1;
          end else begin
            if (illegal) err <= 1'b1;
            trial_out <= trial_next;
            if (k != '0) k <= k - KW'(1);
          end
`else
          if (illegal) err <= 1'b1;
          trial_out <= trial_next;
          if (k != '0) k <= k - KW'(1);
`endif
        end
        CHECK: begin
          if (illegal) err <= 1'b1;
          found  <= equal;
          result <= trial_out;
        end
        default: ;
      endcase
    end
  end

endmodule
